gpu_sequencer: RTL and testbench

//  Per-pixel program sequencer for the GPU core array. Holds a small shader program and, on each

---
 rtl/gpu_sequencer.sv | 66 ++++++
 tb/tb_gpu_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gpu_sequencer.sv
// gpu_sequencer: per-pixel shader opcode sequencer driving the broadcast global registers
module gpu_sequencer #(
  parameter int BIT_WIDTH  = 8,
  parameter int PROG_DEPTH = 16,
  parameter int PC_W       = $clog2(PROG_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   prog_we,
  input  logic [PC_W-2:0]        prog_addr,
  input  logic [15:0]            prog_wdata,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_addr,
  input  logic [BIT_WIDTH-1:0]   cfg_wdata,
  input  logic                   start,
  input  logic [BIT_WIDTH-1:0]   pixel_x,
  input  logic [BIT_WIDTH-1:0]   pixel_y,
  output logic [15:0]            opcode,
  output logic                   execute,
  output logic [9*BIT_WIDTH-1:0] global_registers,
  output logic                   busy,
  output logic                   done,
  output logic                   wr_ignored
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;
  logic [15:0] mem [PROG_DEPTH];
  logic [PC_W-1:0] pc, pc_d;
  logic [15:0] fetch;
  logic fetch_halt, cfg_ok, issue;
  logic [8:0][BIT_WIDTH-1:0] g;
  assign fetch = mem[state == IDLE ? '0 : pc[PC_W-2:0]];
  assign fetch_halt = fetch[15:14] == 2'b11 && !fetch[8] && fetch[7:0] == 8'hFF;
  assign cfg_ok = cfg_addr >= 4'd2 && cfg_addr <= 4'd8;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign global_registers = g;
  always_comb begin
    issue = (state == IDLE && start || state == RUN && pc != PC_W'(PROG_DEPTH)) && !fetch_halt;
    state_d = state == DONE || state == IDLE && !start ? IDLE : issue ? RUN : DONE;
    pc_d = state == IDLE && start ? PC_W'(1) : state == RUN && issue ? pc + PC_W'(1) : pc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      opcode <= '0;
      execute <= 1'b0;
      wr_ignored <= 1'b0;
      g <= '0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      opcode <= issue ? fetch : '0;
      execute <= issue;
      wr_ignored <= prog_we && state != IDLE || cfg_we && !cfg_ok;
      if (state == IDLE && start) begin
        g[0] <= pixel_x;
        g[1] <= pixel_y;
      end
      if (cfg_we && cfg_ok) g[cfg_addr] <= cfg_wdata;
    end
  end
  always_ff @(posedge clk)
    if (prog_we && state == IDLE && !reset) mem[prog_addr] <= prog_wdata;
endmodule

// File: tb/tb_gpu_sequencer.sv
// tb_gpu_sequencer: randomized scoreboard bench for gpu_sequencer
module tb_gpu_sequencer;
  localparam int BW = 8;
  localparam int D = 16;
  localparam int PW = 5;
  logic clk = 1'b0;
  logic reset, prog_we, cfg_we, start, execute, busy, done, wr_ignored;
  logic [PW-2:0] prog_addr;
  logic [15:0] prog_wdata, opcode;
  logic [3:0] cfg_addr;
  logic [BW-1:0] cfg_wdata, pixel_x, pixel_y;
  logic [9*BW-1:0] global_registers;
  always #5 clk = ~clk;
  gpu_sequencer #(.BIT_WIDTH(BW), .PROG_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .start(start),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .opcode(opcode), .execute(execute),
    .global_registers(global_registers), .busy(busy), .done(done), .wr_ignored(wr_ignored)
  );
  int checks = 0;
  int passes = 0;
  logic [15:0] mm [D];
  logic [BW-1:0] gm [9];
  logic [16:0] sb [$];
  logic [16:0] mon_e;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  function automatic logic [9*BW-1:0] gpack();
    logic [9*BW-1:0] r;
    for (int k = 0; k < 9; k++) r[k*BW +: BW] = gm[k];
    return r;
  endfunction
  function automatic bit is_halt(input logic [15:0] w);
    return (w & 16'hC1FF) == 16'hC0FF;
  endfunction
  function automatic logic [15:0] rand_op();
    logic [15:0] w;
    w = 16'($urandom);
    if (is_halt(w)) w[8] = 1'b1;
    return w;
  endfunction
  always @(negedge clk) begin
    if (execute || done) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: execute=%b done=%b opcode=%h, expected idle", execute, done, opcode);
      end else begin
        mon_e = sb.pop_front();
        chk("scoreboard", {done, execute, opcode}, {mon_e[16], !mon_e[16], mon_e[16] ? 16'h0 : mon_e[15:0]});
      end
    end
  end
  task automatic wprog(input int a, input logic [15:0] d);
    prog_we = 1'b1;
    prog_addr = 4'(a);
    prog_wdata = d;
    @(negedge clk);
    prog_we = 1'b0;
    mm[a] = d;
  endtask
  task automatic wcfg(input logic [3:0] a, input logic [BW-1:0] d);
    bit ok;
    ok = a >= 4'd2 && a <= 4'd8;
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (ok) gm[a] = d;
    chk("cfg_wr_ignored", wr_ignored, !ok);
    chk("cfg_globals", global_registers, gpack());
  endtask
  task automatic run(input logic [BW-1:0] x, input logic [BW-1:0] y, input int hook);
    int n = 0;
    int c = 1;
    int bad = 0;
    logic [15:0] nw;
    while (n < D && !is_halt(mm[n])) begin
      sb.push_back({1'b0, mm[n]});
      n++;
    end
    sb.push_back({1'b1, 16'h0});
    gm[0] = x;
    gm[1] = y;
    pixel_x = x;
    pixel_y = y;
    start = 1'b1;
    if (hook == 3) begin
      nw = rand_op();
      prog_we = 1'b1;
      prog_addr = '0;
      prog_wdata = nw;
    end
    @(negedge clk);
    start = 1'b0;
    prog_we = 1'b0;
    if (hook == 3) mm[0] = nw;
    while (!done && c <= 40) begin
      if (!busy) bad++;
      if (hook == 1 && c == 2) begin
        prog_we = 1'b1;
        prog_addr = 4'd1;
        prog_wdata = 16'h7777;
        cfg_we = 1'b1;
        cfg_addr = 4'd5;
        cfg_wdata = 8'hAA;
      end
      if (hook == 1 && c == 3) begin
        chk("busy_prog_we_ignored", wr_ignored, 1);
        gm[5] = 8'hAA;
        chk("cfg_mid_run", global_registers, gpack());
        prog_we = 1'b0;
        cfg_addr = 4'd0;
        cfg_wdata = 8'h55;
      end
      if (hook == 1 && c == 4) begin
        chk("cfg_addr0_ignored", wr_ignored, 1);
        cfg_we = 1'b0;
      end
      if (hook == 2 && c == 2) begin
        start = 1'b1;
        pixel_x = ~x;
        pixel_y = ~y;
      end
      if (hook == 2 && c == 3) start = 1'b0;
      @(negedge clk);
      c++;
    end
    chk("done_cycle", c, n + 1);
    chk("busy_window", bad, 0);
    chk("busy_at_done", busy, 1);
    @(negedge clk);
    chk("idle_after_done", {busy, done, execute, opcode}, 0);
    chk("globals_after_run", global_registers, gpack());
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    prog_we = 1'b0;
    cfg_we = 1'b0;
    start = 1'b0;
    prog_addr = '0;
    prog_wdata = '0;
    cfg_addr = '0;
    cfg_wdata = '0;
    pixel_x = '0;
    pixel_y = '0;
    for (int k = 0; k < 9; k++) gm[k] = '0;
    for (int k = 0; k < D; k++) mm[k] = 16'hC0FF;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {opcode, execute, busy, done, wr_ignored}, 0);
    chk("reset_globals", global_registers, 0);
    reset = 1'b0;
    @(negedge clk);
    wprog(0, 16'h4001);
    wprog(1, 16'h4203);
    wprog(2, 16'h4402);
    wprog(3, 16'hC0FF);
    run(8'h12, 8'h34, 0);
    chk("g0_g1_basic", global_registers[15:0], 16'h3412);
    wprog(0, 16'hC0FF);
    run(8'($urandom), 8'($urandom), 0);
    repeat (6) wcfg(4'($urandom_range(0, 15)), 8'($urandom));
    for (int i = 0; i < D; i++) wprog(i, 16'h0001);
    run(8'($urandom), 8'($urandom), 0);
    repeat (5) begin
      int l;
      l = $urandom_range(0, D);
      for (int i = 0; i < l; i++) wprog(i, rand_op());
      if (l < D) wprog(l, {2'b11, 5'($urandom), 1'b0, 8'hFF});
      run(8'($urandom), 8'($urandom), 0);
    end
    for (int i = 0; i < 5; i++) wprog(i, rand_op());
    wprog(5, 16'hC0FF);
    run(8'($urandom), 8'($urandom), 1);
    run(8'($urandom), 8'($urandom), 2);
    run(8'($urandom), 8'($urandom), 3);
    run(8'($urandom), 8'($urandom), 0);
    sb.push_back({1'b0, mm[0]});
    sb.push_back({1'b0, mm[1]});
    pixel_x = 8'h5A;
    pixel_y = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_run", {execute, done, busy, opcode}, 0);
    chk("reset_mid_run_globals", global_registers, 0);
    sb.delete();
    for (int k = 0; k < 9; k++) gm[k] = '0;
    reset = 1'b0;
    @(negedge clk);
    chk("no_done_after_reset", {done, busy}, 0);
    run(8'($urandom), 8'($urandom), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
